tone_decoder: RTL

//  Receive-side counterpart of the beep PWM tone generator. Measures the period
//  of an incoming square-wave/PWM tone and decodes it to one of seven notes
//  (DO..SI). Reports the note once it is stable. Flags silence after a timeout.

---
 rtl/tone_decoder_if.sv | 22 ++
 rtl/tone_decoder.sv | 169 ++++++++++++++++
 2 files changed

// File: rtl/tone_decoder_if.sv
// Bundle carrying the tone input pin and the decoded-note result from tone_decoder.
// note_vld is a one-cycle strobe with no ready: a consumer samples note/locked/period in the cycle it is high.
interface tone_decoder_if #(
  parameter int CNT_W = 20
);
  logic             pwm_in;
  logic [2:0]       note;
  logic             note_vld;
  logic             locked;
  logic [CNT_W-1:0] period;
  logic [1:0]       dbg_state;

  modport master (
    input  pwm_in,
    output note, note_vld, locked, period, dbg_state
  );

  modport slave (
    output pwm_in,
    input  note, note_vld, locked, period, dbg_state
  );
endinterface

// File: rtl/tone_decoder.sv
// Measures the period of an incoming tone and decodes it to one of seven notes (DO..SI),
// reporting a note only after several consecutive matching periods and flagging silence on timeout.
module tone_decoder #(
  parameter int CNT_W     = 20,
  parameter int P_DO      = 191113,
  parameter int P_RE      = 170262,
  parameter int P_MI      = 151686,
  parameter int P_FA      = 143173,
  parameter int P_SO      = 127551,
  parameter int P_LA      = 113636,
  parameter int P_SI      = 101235,
  parameter int TOL_SHIFT = 6,
  parameter int MATCH_CNT = 3,
  parameter int TIMEOUT   = 400000
) (
  input  logic             clk,
  input  logic             rst,
  tone_decoder_if.master   bus
);

  localparam int MW = $clog2(MATCH_CNT + 1);
  localparam int P_TAB [7] = '{P_DO, P_RE, P_MI, P_FA, P_SO, P_LA, P_SI};

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_MEAS = 2'd1
  } state_t;

  state_t           state_q, state_d;
  logic             meta_q, s1_q, s2_q;
  logic             edge_w;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [2:0]       cand_q, cand_d;
  logic [MW-1:0]    match_q, match_d, match_new;
  logic [2:0]       note_q, note_d;
  logic             locked_q, locked_d;
  logic [CNT_W-1:0] period_q, period_d;
  logic             vld_q, vld_d;
  logic [2:0]       k;

  // The pin is asynchronous: two flops for metastability, a third to find the rising edge.
  always_ff @(posedge clk) begin
    if (rst) begin
      meta_q <= 1'b0;
      s1_q   <= 1'b0;
      s2_q   <= 1'b0;
    end else begin
      meta_q <= bus.pwm_in;
      s1_q   <= meta_q;
      s2_q   <= s1_q;
    end
  end

  assign edge_w = s1_q & ~s2_q;

  // Scanning from SI down to DO lets the lowest matching index overwrite higher ones.
  function automatic logic [2:0] classify(input logic [CNT_W-1:0] c);
    logic [2:0]  res;
    logic [31:0] cv;
    logic [31:0] p;
    logic [31:0] tol;
    res = 3'd0;
    cv  = 32'(c);
    for (int i = 6; i >= 0; i--) begin
      p   = 32'(P_TAB[i]);
      tol = p >> TOL_SHIFT;
      if ((cv + tol >= p) && (cv <= p + tol)) begin
        res = 3'(i + 1);
      end
    end
    return res;
  endfunction

  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    cand_d    = cand_q;
    match_d   = match_q;
    note_d    = note_q;
    locked_d  = locked_q;
    period_d  = period_q;
    vld_d     = 1'b0;
    match_new = match_q;
    k         = classify(cnt_q);

    unique case (state_q)
      S_IDLE: begin
        cnt_d = '0;
        if (edge_w) begin
          cnt_d   = CNT_W'(1);
          state_d = S_MEAS;
        end
      end

      S_MEAS: begin
        if (edge_w) begin
          period_d = cnt_q;
          cnt_d    = CNT_W'(1);
          if (k == 3'd0) begin
            // An unrecognised period breaks the streak but does not drop an existing lock.
            cand_d  = 3'd0;
            match_d = '0;
          end else begin
            if (k != cand_q) begin
              match_new = MW'(1);
            end else if (match_q >= MW'(MATCH_CNT)) begin
              match_new = match_q;
            end else begin
              match_new = match_q + MW'(1);
            end
            cand_d  = k;
            match_d = match_new;
            if ((match_new >= MW'(MATCH_CNT)) && (k != note_q)) begin
              note_d   = k;
              locked_d = 1'b1;
              vld_d    = 1'b1;
            end
          end
        end else if (cnt_q >= CNT_W'(TIMEOUT)) begin
          state_d = S_IDLE;
          cnt_d   = '0;
          cand_d  = 3'd0;
          match_d = '0;
          if (note_q != 3'd0) begin
            note_d   = 3'd0;
            locked_d = 1'b0;
            vld_d    = 1'b1;
          end
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end

      default: begin
        state_d = S_IDLE;
        cnt_d   = '0;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q  <= S_IDLE;
      cnt_q    <= '0;
      cand_q   <= 3'd0;
      match_q  <= '0;
      note_q   <= 3'd0;
      locked_q <= 1'b0;
      period_q <= '0;
      vld_q    <= 1'b0;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      cand_q   <= cand_d;
      match_q  <= match_d;
      note_q   <= note_d;
      locked_q <= locked_d;
      period_q <= period_d;
      vld_q    <= vld_d;
    end
  end

  assign bus.note      = note_q;
  assign bus.note_vld  = vld_q;
  assign bus.locked    = locked_q;
  assign bus.period    = period_q;
  assign bus.dbg_state = state_q;

endmodule
